// File: rtl/multicycle_control_fsm.sv
// Purpose  : main control FSM of the multi-cycle RISC-V core. It steps each instruction
//            through fetch, decode, execute, memory and writeback, one state per clock.
// Latency  : lw 5 cycles; sw, R-type, I-ALU and jal 4 cycles; beq 3 cycles.
//            Each cycle of MemReady=0 in FETCH, MEMREAD or MEMWRITE adds one cycle.
// Backpres.: the FSM holds FETCH, MEMREAD or MEMWRITE until MemReady=1. While it holds
//            FETCH it does not load the IR and does not increment the PC.
// Ports    : clk/rst (synchronous, active-low); Op/funct3/funct7b5 come from the IR;
//            Zero comes from the ALU; MemReady is the memory handshake.
//            Outputs drive the immediate extender (ImmSrc), the ALU muxes and ALUControl,
//            the result mux, the address mux and the IR/PC/RF/memory write enables.
//            IllegalOp is a sticky flag. State is for debug.
module multicycle_control_fsm #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [6:0]         Op,
  input  logic [2:0]         funct3,
  input  logic               funct7b5,
  input  logic               Zero,
  input  logic               MemReady,
  output logic [1:0]         ImmSrc,
  output logic [1:0]         ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [2:0]         ALUControl,
  output logic [1:0]         ResultSrc,
  output logic               AdrSrc,
  output logic               IRWrite,
  output logic               PCWrite,
  output logic               RegWrite,
  output logic               MemWrite,
  output logic               IllegalOp,
  output logic [STATE_W-1:0] State
);

  typedef enum logic [STATE_W-1:0] {
    S_FETCH    = STATE_W'(0),
    S_DECODE   = STATE_W'(1),
    S_MEMADR   = STATE_W'(2),
    S_MEMREAD  = STATE_W'(3),
    S_MEMWB    = STATE_W'(4),
    S_MEMWRITE = STATE_W'(5),
    S_EXECR    = STATE_W'(6),
    S_ALUWB    = STATE_W'(7),
    S_EXECI    = STATE_W'(8),
    S_JAL      = STATE_W'(9),
    S_BEQ      = STATE_W'(10)
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;

  state_t     r_state;
  logic       r_illegal;

  logic [1:0] w_alu_op;
  logic       w_pc_update;
  logic       w_branch;
  logic       w_ir_write;
  logic       w_reg_write;
  logic       w_mem_write;

  // State register and sticky illegal-opcode flag
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_FETCH;
      r_illegal <= 1'b0;
    end else begin
      case (r_state)
        S_FETCH:    if (MemReady) r_state <= S_DECODE;
        S_DECODE: begin
          case (Op)
            OP_LW, OP_SW: r_state <= S_MEMADR;
            OP_R:         r_state <= S_EXECR;
            OP_I:         r_state <= S_EXECI;
            OP_JAL:       r_state <= S_JAL;
            OP_BEQ:       r_state <= S_BEQ;
            default: begin
              r_state   <= S_FETCH;
              r_illegal <= 1'b1;
            end
          endcase
        end
        S_MEMADR:   r_state <= (Op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
        S_MEMREAD:  if (MemReady) r_state <= S_MEMWB;
        S_MEMWB:    r_state <= S_FETCH;
        S_MEMWRITE: if (MemReady) r_state <= S_FETCH;
        S_EXECR:    r_state <= S_ALUWB;
        S_EXECI:    r_state <= S_ALUWB;
        S_ALUWB:    r_state <= S_FETCH;
        S_JAL:      r_state <= S_ALUWB;
        S_BEQ:      r_state <= S_FETCH;
        default:    r_state <= S_FETCH;   // codes 11-15 recover to FETCH
      endcase
    end
  end

  // Moore decode of the datapath controls from the current state
  always_comb begin
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    ResultSrc   = 2'b00;
    AdrSrc      = 1'b0;
    w_alu_op    = 2'b00;
    w_pc_update = 1'b0;
    w_branch    = 1'b0;
    w_ir_write  = 1'b0;
    w_reg_write = 1'b0;
    w_mem_write = 1'b0;
    case (r_state)
      S_FETCH: begin
        ALUSrcB     = 2'b10;
        ResultSrc   = 2'b10;
        // The IR load and the PC+4 update both wait for the fetch to complete
        w_ir_write  = MemReady;
        w_pc_update = MemReady;
      end
      S_DECODE: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      S_MEMADR: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      S_MEMREAD: begin
        AdrSrc = 1'b1;
      end
      S_MEMWB: begin
        ResultSrc   = 2'b01;
        w_reg_write = 1'b1;
      end
      S_MEMWRITE: begin
        AdrSrc      = 1'b1;
        w_mem_write = 1'b1;
      end
      S_EXECR: begin
        ALUSrcA  = 2'b10;
        w_alu_op = 2'b10;
      end
      S_EXECI: begin
        ALUSrcA  = 2'b10;
        ALUSrcB  = 2'b01;
        w_alu_op = 2'b10;
      end
      S_ALUWB: begin
        w_reg_write = 1'b1;
      end
      S_JAL: begin
        ALUSrcA     = 2'b01;
        ALUSrcB     = 2'b10;
        w_pc_update = 1'b1;
      end
      S_BEQ: begin
        ALUSrcA  = 2'b10;
        w_alu_op = 2'b01;
        w_branch = 1'b1;
      end
      default: ;
    endcase
  end

  // The immediate format depends only on the opcode
  always_comb begin
    case (Op)
      OP_SW:   ImmSrc = 2'b01;
      OP_BEQ:  ImmSrc = 2'b10;
      OP_JAL:  ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  // ALU decoder. Op[5] tells R-type from I-type, so funct7b5 cannot turn addi into sub.
  always_comb begin
    case (w_alu_op)
      2'b00: ALUControl = 3'b000;
      2'b01: ALUControl = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  ALUControl = (Op[5] & funct7b5) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

  // Write enables are gated by rst directly. A reset that arrives mid-instruction
  // therefore cannot commit a write on the reset edge.
  assign IRWrite   = rst & w_ir_write;
  assign PCWrite   = rst & (w_pc_update | (w_branch & Zero));
  assign RegWrite  = rst & w_reg_write;
  assign MemWrite  = rst & w_mem_write;
  assign IllegalOp = r_illegal;
  assign State     = r_state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
module tb_multicycle_control_fsm;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] Op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       Zero;
  logic       MemReady;
  logic [1:0] ImmSrc, ALUSrcA, ALUSrcB, ResultSrc;
  logic [2:0] ALUControl;
  logic       AdrSrc, IRWrite, PCWrite, RegWrite, MemWrite, IllegalOp;
  logic [3:0] State;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  multicycle_control_fsm #(.STATE_W(4)) dut (
    .clk(clk), .rst(rst), .Op(Op), .funct3(funct3), .funct7b5(funct7b5),
    .Zero(Zero), .MemReady(MemReady), .ImmSrc(ImmSrc), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ResultSrc(ResultSrc),
    .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite),
    .MemWrite(MemWrite), .IllegalOp(IllegalOp), .State(State)
  );

  task automatic test_reset();
    rst = 1'b0; MemReady = 1'b1; Op = 7'b0000011; funct3 = 3'b000;
    funct7b5 = 1'b0; Zero = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      n_vec++;
      if (State !== 4'd0 || IRWrite !== 1'b0 || PCWrite !== 1'b0 ||
          RegWrite !== 1'b0 || MemWrite !== 1'b0 || IllegalOp !== 1'b0) begin
        n_err++;
        $display("FAIL reset_hold[%0d]: State=%0d IR=%b PC=%b RW=%b MW=%b Ill=%b, want 0 for all",
                 i, State, IRWrite, PCWrite, RegWrite, MemWrite, IllegalOp);
      end
    end
    rst = 1'b1; #1;
    n_vec++;
    if (State !== 4'd0 || IRWrite !== 1'b1 || PCWrite !== 1'b1 || ALUSrcB !== 2'b10) begin
      n_err++;
      $display("FAIL reset_release: State=%0d IR=%b PC=%b SrcB=%b, want 0 1 1 10",
               State, IRWrite, PCWrite, ALUSrcB);
    end
  endtask

  task automatic test_lw();
    logic [3:0] es [6] = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd0};
    logic       rw [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    Op = 7'b0000011; MemReady = 1'b1;
    for (int i = 0; i < 6; i++) begin
      #1;
      n_vec++;
      if (State !== es[i] || RegWrite !== rw[i] || ImmSrc !== 2'b00) begin
        n_err++;
        $display("FAIL lw[%0d]: State=%0d RW=%b Imm=%b, want %0d %b 00",
                 i, State, RegWrite, ImmSrc, es[i], rw[i]);
      end
      if (i == 4) begin
        n_vec++;
        if (ResultSrc !== 2'b01) begin
          n_err++; $display("FAIL lw_memwb_result: ResultSrc=%b, want 01", ResultSrc);
        end
      end
      if (i == 3) begin
        n_vec++;
        if (AdrSrc !== 1'b1) begin
          n_err++; $display("FAIL lw_memread_adr: AdrSrc=%b, want 1", AdrSrc);
        end
      end
      if (i < 5) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_sw_stall();
    logic [3:0] es [8] = '{4'd0, 4'd1, 4'd2, 4'd5, 4'd5, 4'd5, 4'd5, 4'd0};
    logic       mr [8] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic       mw [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [3:0] prev = 4'd0;
    int         n_exit = 0;
    Op = 7'b0100011;
    for (int i = 0; i < 8; i++) begin
      MemReady = mr[i];
      #1;
      if (prev == 4'd5 && State == 4'd0) n_exit++;
      prev = State;
      n_vec++;
      if (State !== es[i] || MemWrite !== mw[i] || ImmSrc !== 2'b01 || RegWrite !== 1'b0) begin
        n_err++;
        $display("FAIL sw[%0d]: State=%0d MW=%b Imm=%b RW=%b, want %0d %b 01 0",
                 i, State, MemWrite, ImmSrc, RegWrite, es[i], mw[i]);
      end
      if (i < 7) begin @(posedge clk); #1; end
    end
    n_vec++;
    if (n_exit != 1) begin
      n_err++; $display("FAIL sw_exit_count: %0d transitions to FETCH, want 1", n_exit);
    end
  endtask

  task automatic test_fetch_stall();
    logic [3:0] es  [7] = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd8, 4'd7, 4'd0};
    logic       mr  [7] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic       wen [7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    Op = 7'b0010011; funct3 = 3'b000; funct7b5 = 1'b0;
    for (int i = 0; i < 7; i++) begin
      MemReady = mr[i];
      #1;
      n_vec++;
      if (State !== es[i] || IRWrite !== wen[i] || PCWrite !== wen[i]) begin
        n_err++;
        $display("FAIL fetch_stall[%0d]: State=%0d IR=%b PC=%b, want %0d %b %b",
                 i, State, IRWrite, PCWrite, es[i], wen[i], wen[i]);
      end
      if (i < 6) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_alu(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                          input logic [3:0] exec_st, input logic [2:0] exp_ctl,
                          input logic [1:0] exp_srcb);
    logic [3:0] es [5];
    es = '{4'd0, 4'd1, exec_st, 4'd7, 4'd0};
    Op = op; funct3 = f3; funct7b5 = f7; MemReady = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_vec++;
      if (State !== es[i] || RegWrite !== (i == 3)) begin
        n_err++;
        $display("FAIL alu_seq op=%b f3=%b [%0d]: State=%0d RW=%b, want %0d %b",
                 op, f3, i, State, RegWrite, es[i], (i == 3));
      end
      if (i == 2) begin
        n_vec++;
        if (ALUControl !== exp_ctl || ALUSrcA !== 2'b10 || ALUSrcB !== exp_srcb) begin
          n_err++;
          $display("FAIL alu_exec op=%b f3=%b f7=%b: ctl=%b A=%b B=%b, want %b 10 %b",
                   op, f3, f7, ALUControl, ALUSrcA, ALUSrcB, exp_ctl, exp_srcb);
        end
      end
      if (i < 4) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_branch(input logic z);
    logic [3:0] es [4] = '{4'd0, 4'd1, 4'd10, 4'd0};
    Op = 7'b1100011; Zero = z; MemReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_vec++;
      if (State !== es[i] || ImmSrc !== 2'b10) begin
        n_err++;
        $display("FAIL beq_seq z=%b [%0d]: State=%0d Imm=%b, want %0d 10",
                 z, i, State, ImmSrc, es[i]);
      end
      if (i == 2) begin
        n_vec++;
        if (PCWrite !== z || ALUControl !== 3'b001 || RegWrite !== 1'b0) begin
          n_err++;
          $display("FAIL beq_exec z=%b: PC=%b ctl=%b RW=%b, want %b 001 0",
                   z, PCWrite, ALUControl, RegWrite, z);
        end
      end
      if (i < 3) begin @(posedge clk); #1; end
    end
    Zero = 1'b0;
  endtask

  task automatic test_jal();
    logic [3:0] es [5] = '{4'd0, 4'd1, 4'd9, 4'd7, 4'd0};
    Op = 7'b1101111; MemReady = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_vec++;
      if (State !== es[i] || ImmSrc !== 2'b11) begin
        n_err++;
        $display("FAIL jal_seq[%0d]: State=%0d Imm=%b, want %0d 11", i, State, ImmSrc, es[i]);
      end
      if (i == 2) begin
        n_vec++;
        if (PCWrite !== 1'b1 || ALUSrcA !== 2'b01 || ALUSrcB !== 2'b10) begin
          n_err++;
          $display("FAIL jal_exec: PC=%b A=%b B=%b, want 1 01 10", PCWrite, ALUSrcA, ALUSrcB);
        end
      end
      if (i == 3) begin
        n_vec++;
        if (RegWrite !== 1'b1 || ResultSrc !== 2'b00) begin
          n_err++;
          $display("FAIL jal_wb: RW=%b Res=%b, want 1 00", RegWrite, ResultSrc);
        end
      end
      if (i < 4) begin @(posedge clk); #1; end
    end
  endtask

  task automatic test_illegal();
    logic [3:0] es  [3] = '{4'd0, 4'd1, 4'd0};
    logic       ill [3] = '{1'b0, 1'b0, 1'b1};
    logic [3:0] es2 [5] = '{4'd0, 4'd1, 4'd8, 4'd7, 4'd0};
    Op = 7'b1111111; MemReady = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_vec++;
      if (State !== es[i] || IllegalOp !== ill[i]) begin
        n_err++;
        $display("FAIL illegal[%0d]: State=%0d Ill=%b, want %0d %b", i, State, IllegalOp, es[i], ill[i]);
      end
      if (i < 2) begin @(posedge clk); #1; end
    end
    Op = 7'b0010011; funct3 = 3'b000; funct7b5 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      n_vec++;
      if (State !== es2[i] || IllegalOp !== 1'b1) begin
        n_err++;
        $display("FAIL illegal_sticky[%0d]: State=%0d Ill=%b, want %0d 1", i, State, IllegalOp, es2[i]);
      end
      if (i < 4) begin @(posedge clk); #1; end
    end
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1; #1;
    n_vec++;
    if (IllegalOp !== 1'b0 || State !== 4'd0) begin
      n_err++;
      $display("FAIL illegal_clear: Ill=%b State=%0d, want 0 0", IllegalOp, State);
    end
  endtask

  task automatic test_reset_in_memwrite();
    logic [3:0] es [4] = '{4'd0, 4'd1, 4'd2, 4'd5};
    logic       mr [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    Op = 7'b0100011;
    for (int i = 0; i < 4; i++) begin
      MemReady = mr[i];
      #1;
      n_vec++;
      if (State !== es[i]) begin
        n_err++; $display("FAIL rst_mw_seq[%0d]: State=%0d, want %0d", i, State, es[i]);
      end
      if (i < 3) begin @(posedge clk); #1; end
    end
    n_vec++;
    if (MemWrite !== 1'b1) begin
      n_err++; $display("FAIL rst_mw_pre: MemWrite=%b, want 1", MemWrite);
    end
    rst = 1'b0; #1;
    n_vec++;
    if (MemWrite !== 1'b0 || RegWrite !== 1'b0 || PCWrite !== 1'b0 || IRWrite !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mw_gate: MW=%b RW=%b PC=%b IR=%b, want 0 0 0 0",
               MemWrite, RegWrite, PCWrite, IRWrite);
    end
    MemReady = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (State !== 4'd0 || MemWrite !== 1'b0) begin
      n_err++; $display("FAIL rst_mw_after: State=%0d MW=%b, want 0 0", State, MemWrite);
    end
    rst = 1'b1; #1;
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw_stall();
    test_fetch_stall();
    test_alu(7'b0110011, 3'b000, 1'b1, 4'd6, 3'b001, 2'b00);  // sub
    test_alu(7'b0010011, 3'b000, 1'b1, 4'd8, 3'b000, 2'b01);  // addi, funct7b5 ignored
    test_alu(7'b0110011, 3'b010, 1'b0, 4'd6, 3'b101, 2'b00);  // slt
    test_alu(7'b0110011, 3'b110, 1'b0, 4'd6, 3'b011, 2'b00);  // or
    test_alu(7'b0010011, 3'b111, 1'b0, 4'd8, 3'b010, 2'b01);  // andi
    test_branch(1'b1);
    test_branch(1'b0);
    test_jal();
    test_illegal();
    test_reset_in_memwrite();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_control_fsm.md
Name: multicycle_control_fsm

Overview:
Main control unit for the multi-cycle RISC-V core. It sequences each instruction through fetch, decode, execute, memory and writeback states, with one state per clock. It configures the shared datapath resources: the immediate extender (ImmSrc), the single ALU (source muxes and ALUControl), the unified memory address mux, and the PC, IR and register-file write enables. Memory accesses stall on a ready handshake.

Parameters:
STATE_W, 4, width of the state register and of the State debug output.

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-low reset
Op  input  7  instr[6:0]
funct3  input  3  instr[14:12]
funct7b5  input  1  instr[30]
Zero  input  1  ALU zero flag
MemReady  input  1  memory completes the access this cycle
ImmSrc  output  2  00 I, 01 S, 10 B, 11 J
ALUSrcA  output  2  00 PC, 01 OldPC, 10 RD1
ALUSrcB  output  2  00 RD2, 01 ImmExt, 10 constant 4
ALUControl  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
ResultSrc  output  2  00 ALUOut, 01 ReadData, 10 ALUResult
AdrSrc  output  1  0 PC, 1 Result
IRWrite  output  1  instruction register load
PCWrite  output  1  PC load
RegWrite  output  1  register-file write
MemWrite  output  1  data memory write
IllegalOp  output  1  sticky unsupported-opcode flag
State  output  STATE_W  current state, for debug

Behaviour:
- Reset:
  - rst=0 at a rising edge gives State=FETCH and IllegalOp=0.
  - While rst=0, IRWrite, PCWrite, RegWrite and MemWrite are forced to 0 combinationally.
  - Reset mid-instruction abandons the instruction; no partial write occurs on or after the reset edge.
- Output model:
  - Moore outputs decoded from State.
  - Exceptions: PCWrite = PCUpdate | (Branch & Zero); ImmSrc and ALUControl are decoded from Op, funct3 and funct7b5.
  - Any output not listed for a state is 0.
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, ALUWB=7, EXECI=8, JAL=9, BEQ=10. Codes 11-15 go to FETCH on the next edge.
- FETCH:
  - AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10.
  - IRWrite=PCUpdate=MemReady.
  - MemReady=1: go to DECODE. MemReady=0: stay in FETCH; the PC is not incremented.
- DECODE:
  - ALUSrcA=01, ALUSrcB=01, ALUOp=00 (branch target to ALUOut).
  - Next state by Op: 0000011 or 0100011 to MEMADR; 0110011 to EXECR; 0010011 to EXECI; 1101111 to JAL; 1100011 to BEQ.
  - Any other Op: go to FETCH and set IllegalOp=1.
- MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. Go to MEMREAD if Op=0000011, else MEMWRITE.
- MEMREAD: ResultSrc=00, AdrSrc=1. Hold until MemReady=1, then go to MEMWB.
- MEMWB: ResultSrc=01, RegWrite=1. Go to FETCH.
- MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1 held until MemReady=1, then go to FETCH.
- EXECR: ALUSrcA=10, ALUSrcB=00, ALUOp=10. Go to ALUWB.
- EXECI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. Go to ALUWB.
- ALUWB: ResultSrc=00, RegWrite=1. Go to FETCH.
- JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1. Go to ALUWB.
- BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1. Go to FETCH.
- ImmSrc decode: 0100011 gives 01; 1100011 gives 10; 1101111 gives 11; all other Op give 00.
- ALUControl decode:
  - ALUOp=00: 000. ALUOp=01: 001.
  - ALUOp=10, by funct3: 000 gives 001 if (Op[5] & funct7b5), else 000; 010 gives 101; 110 gives 011; 111 gives 010; other funct3 give 000.
- Instruction latency with MemReady held at 1:
  - lw 5 cycles; sw 4; R-type 4; I-ALU 4; jal 4; beq 3.
  - Each cycle with MemReady=0 in a memory state adds one cycle.
- IllegalOp stays 1 until reset.

Test Plan:
- Reset: hold rst=0 for 2 cycles with MemReady=1 -> State=0 and IRWrite=PCWrite=RegWrite=MemWrite=0 every cycle; after release, first cycle has IRWrite=1, PCWrite=1, ALUSrcB=10.
- lw (Op=0000011), MemReady=1 -> State sequence 0,1,2,3,4,0; ImmSrc=00; RegWrite=1 only in state 4 with ResultSrc=01.
- sw (Op=0100011) with MemReady=0 for 3 cycles in MEMWRITE -> ImmSrc=01; MemWrite=1 for 4 cycles; exactly one transition to FETCH.
- R-type sub (Op=0110011, funct3=000, funct7b5=1) -> ALUControl=001 in EXECR; the same with Op=0010011 (addi) -> ALUControl=000.
- beq with Zero=1 -> PCWrite=1 in BEQ, ImmSrc=10; with Zero=0 -> PCWrite=0. jal -> PCWrite=1 in JAL, ImmSrc=11, then ALUWB writes the register.
- Op=1111111 -> DECODE to FETCH, IllegalOp=1 stays set through subsequent instructions; rst=0 for 1 cycle clears it; rst=0 asserted in MEMWRITE -> MemWrite=0 in that same cycle.
